// File: rtl/cas_tape_loader_if.sv
// cas_tape_loader_if: HPS ioctl download stream (HPS side drives, loader receives)
interface cas_tape_loader_if;
    logic        download;
    logic [7:0]  index;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  data;
    modport master (output download, index, wr, addr, data);
    modport slave  (input  download, index, wr, addr, data);
endinterface

// File: rtl/cas_tape_loader.sv
// cas_tape_loader: captures CAS ioctl downloads into cassette SRAM, tracks tape length/overflow, muxes SRAM address with the player.
// Optional CAS_CHECKSUM_EN adds csum_o (mod-256 sum of bytes written by the last load) and csum_valid_o.
module cas_tape_loader #(
    parameter logic [7:0] TAPE_INDEX = 8'd2,
    parameter int         ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    cas_tape_loader_if.slave  ioctl,
    input  logic [ADDR_W-1:0] play_addr_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_din_o,
    output logic              ram_we_o,
    output logic [ADDR_W:0]   tape_len_o,
    output logic              tape_loaded_o,
    output logic              tape_end_o,
    output logic              rewind_o,
    output logic              overflow_o,
    output logic              loading_o
`ifdef CAS_CHECKSUM_EN
    ,
    output logic [7:0]        csum_o,
    output logic              csum_valid_o
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t            state_q, state_d;
    logic              sel, sel_q, start, in_range, accept, drop;
    logic [ADDR_W:0]   new_len, tape_len_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [7:0]        ram_din_q;
    logic              ram_we_q, tape_loaded_q, overflow_q, rewind_q;

    assign sel      = ioctl.download & (ioctl.index == TAPE_INDEX);
    assign start    = (state_q == IDLE) & sel & ~sel_q;
    assign in_range = (ioctl.addr >> ADDR_W) == 25'd0;
    // Strobes are taken on any LOAD cycle, so a byte coinciding with the download falling edge still lands.
    assign accept   = (state_q == LOAD) & ioctl.wr & in_range;
    assign drop     = (state_q == LOAD) & ioctl.wr & ~in_range;
    assign new_len  = {1'b0, ioctl.addr[ADDR_W-1:0]} + {{ADDR_W{1'b0}}, 1'b1};

    // Next-state: IDLE waits for a tape download edge, LOAD runs until the download drops, COMMIT lasts one cycle.
    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE) ? (start ? LOAD : IDLE) :
                  (state_q == LOAD) ? (sel ? LOAD : COMMIT) : IDLE;
    end

    // State register and download-select edge detector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel;
        end
    end

    // SRAM port: loader write one cycle after its strobe, otherwise the player address (held during LOAD).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
        end else begin
            ram_we_q   <= accept;
            ram_din_q  <= accept ? ioctl.data : ram_din_q;
            ram_addr_q <= accept ? ioctl.addr[ADDR_W-1:0] : (state_q == LOAD) ? ram_addr_q : play_addr_i;
        end
    end

    // Tape status: length grows to the highest byte written, overflow is sticky, loaded/rewind settle at COMMIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tape_len_q    <= '0;
            tape_loaded_q <= 1'b0;
            overflow_q    <= 1'b0;
            rewind_q      <= 1'b0;
        end else begin
            tape_len_q    <= start ? '0 : (accept && new_len > tape_len_q) ? new_len : tape_len_q;
            overflow_q    <= start ? 1'b0 : drop ? 1'b1 : overflow_q;
            tape_loaded_q <= start ? 1'b0 : (state_q == COMMIT) ? (tape_len_q != '0) : tape_loaded_q;
            rewind_q      <= start | (state_q == COMMIT);
        end
    end

    assign ram_addr_o    = ram_addr_q;
    assign ram_din_o     = ram_din_q;
    assign ram_we_o      = ram_we_q;
    assign tape_len_o    = tape_len_q;
    assign tape_loaded_o = tape_loaded_q;
    assign overflow_o    = overflow_q;
    assign rewind_o      = rewind_q;
    assign loading_o     = (state_q == LOAD);
    assign tape_end_o    = tape_loaded_q & (state_q != LOAD) & ({1'b0, play_addr_i} >= tape_len_q);

`ifdef CAS_CHECKSUM_EN
    logic [7:0] csum_q;

    // Running mod-256 sum of accepted bytes, restarted at each load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) csum_q <= '0;
        else          csum_q <= start ? 8'd0 : accept ? csum_q + ioctl.data : csum_q;
    end

    assign csum_o       = csum_q;
    assign csum_valid_o = tape_loaded_q;
`endif
endmodule

// File: tb/tb_cas_tape_loader.sv
// tb_cas_tape_loader: directed bench with a write scoreboard for cas_tape_loader (ADDR_W = 4).
module tb_cas_tape_loader;
    localparam int AW = 4;

    typedef struct {
        int         cyc;
        logic [3:0] a;
        logic [7:0] d;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] play_addr = 4'd9;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we, tape_loaded, tape_end, rewind, overflow, loading;
    logic [AW:0]   tape_len;
`ifdef CAS_CHECKSUM_EN
    logic [7:0]    csum;
    logic          csum_valid;
`endif

    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rw_cnt = 0;
    exp_t q[$];

    cas_tape_loader_if bus ();

    cas_tape_loader #(.TAPE_INDEX(8'd2), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .ioctl(bus.slave), .play_addr_i(play_addr),
        .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_we_o(ram_we), .tape_len_o(tape_len),
        .tape_loaded_o(tape_loaded), .tape_end_o(tape_end), .rewind_o(rewind),
        .overflow_o(overflow), .loading_o(loading)
`ifdef CAS_CHECKSUM_EN
        , .csum_o(csum), .csum_valid_o(csum_valid)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && rewind) rw_cnt++;
        if (reset_n && ram_we) begin
            if (q.size() == 0) chk("unexpected_we", 32'(ram_addr), 32'hFFFF_FFFF);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("we_cycle", 32'(cyc), 32'(e.cyc));
                chk("we_addr", 32'(ram_addr), 32'(e.a));
                chk("we_data", 32'(ram_din), 32'(e.d));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.download = 1'b1;
        bus.index = idx;
        tick();
    endtask

    task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit expect_we);
        bus.wr = 1'b1;
        bus.addr = a;
        bus.data = d;
        if (expect_we) q.push_back('{cyc + 1, a[3:0], d});
        tick();
    endtask

    task automatic end_dl;
        bus.wr = 1'b0;
        bus.download = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        bus.download = 1'b0;
        bus.index = 8'd0;
        bus.wr = 1'b0;
        bus.addr = '0;
        bus.data = '0;
        #1;
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_len", 32'(tape_len), 32'd0);
        chk("rst_loaded", 32'(tape_loaded), 32'd0);
        chk("rst_rewind", 32'(rewind), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("idle_ram_addr_play", 32'(ram_addr), 32'd9);

        // Test 1: four-byte load on the tape index.
        rw_cnt = 0;
        start_dl(8'd2);
        chk("t1_loading", 32'(loading), 32'd1);
        chk("t1_end_forced0", 32'(tape_end), 32'd0);
        wr_byte(25'd0, 8'h11, 1'b1);
        wr_byte(25'd1, 8'h22, 1'b1);
        wr_byte(25'd2, 8'h33, 1'b1);
        wr_byte(25'd3, 8'h44, 1'b1);
        end_dl();
        chk("t1_len", 32'(tape_len), 32'd4);
        chk("t1_loaded", 32'(tape_loaded), 32'd1);
        chk("t1_rewinds", 32'(rw_cnt), 32'd2);
        chk("t1_overflow", 32'(overflow), 32'd0);
        chk("t1_q_empty", 32'(q.size()), 32'd0);

        // Test 2: end-of-tape compare and address mux latency.
        play_addr = 4'd3;
        #1;
        chk("t2_end_at3", 32'(tape_end), 32'd0);
        chk("t2_addr_latency", 32'(ram_addr), 32'd9);
        tick();
        chk("t2_addr_follow", 32'(ram_addr), 32'd3);
        play_addr = 4'd4;
        #1;
        chk("t2_end_at4", 32'(tape_end), 32'd1);

        // Test 4: download on another index is ignored.
        rw_cnt = 0;
        start_dl(8'd1);
        chk("t4_not_loading", 32'(loading), 32'd0);
        wr_byte(25'd0, 8'hAA, 1'b0);
        wr_byte(25'd1, 8'hBB, 1'b0);
        end_dl();
        chk("t4_len", 32'(tape_len), 32'd4);
        chk("t4_loaded", 32'(tape_loaded), 32'd1);
        chk("t4_no_rewind", 32'(rw_cnt), 32'd0);

        // Test 3: 20 bytes into a 16-byte SRAM, then a short reload.
        start_dl(8'd2);
        for (int i = 0; i < 20; i++) wr_byte(25'(i), 8'(i * 7 + 1), i < 16);
        end_dl();
        chk("t3_len_full", 32'(tape_len), 32'd16);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_loaded", 32'(tape_loaded), 32'd1);
        start_dl(8'd2);
        chk("t3_ovf_cleared", 32'(overflow), 32'd0);
        wr_byte(25'd0, 8'h5A, 1'b1);
        wr_byte(25'd1, 8'hA5, 1'b1);
        end_dl();
        chk("t3_len_2", 32'(tape_len), 32'd2);
        chk("t3_ovf_stays0", 32'(overflow), 32'd0);

        // Test 5: reset mid-load abandons the image.
        start_dl(8'd2);
        wr_byte(25'd0, 8'h01, 1'b1);
        wr_byte(25'd1, 8'h02, 1'b1);
        wr_byte(25'd2, 8'h03, 1'b1);
        bus.wr = 1'b0;
        tick();
        reset_n = 1'b0;
        bus.download = 1'b0;
        #1;
        chk("t5_ram_addr", 32'(ram_addr), 32'd0);
        chk("t5_din", 32'(ram_din), 32'd0);
        chk("t5_len", 32'(tape_len), 32'd0);
        chk("t5_loaded", 32'(tape_loaded), 32'd0);
        chk("t5_loading", 32'(loading), 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);
        tick();
        reset_n = 1'b1;
        play_addr = 4'd0;
        tick();
        chk("t5_end", 32'(tape_end), 32'd0);
        chk("t5_q_empty", 32'(q.size()), 32'd0);

        // Test 6: last strobe on the download falling edge.
        start_dl(8'd2);
        wr_byte(25'd0, 8'h01, 1'b1);
        wr_byte(25'd1, 8'hFF, 1'b1);
        bus.download = 1'b0;
        wr_byte(25'd2, 8'h10, 1'b1);
        bus.wr = 1'b0;
        tick();
        tick();
        chk("t6_len", 32'(tape_len), 32'd3);
        chk("t6_loaded", 32'(tape_loaded), 32'd1);
`ifdef CAS_CHECKSUM_EN
        chk("t6_csum", 32'(csum), 32'h10);
        chk("t6_csum_valid", 32'(csum_valid), 32'd1);
`endif
        chk("t6_q_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
